// File: rtl/seq_divider8_if.sv
// Start/busy/done handshake and operand/result bus for the 16-by-8 sequential divider.
// The master drives the request; the slave (the divider) returns status and results.
interface seq_divider8_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/seq_divider8.sv
// Sequential 16-by-8 unsigned restoring divider: one quotient bit per clock.
// Divide-by-zero and quotient overflow are detected at start and finish early.
module seq_divider8 (
    input  logic           clk,
    input  logic           rst_n,
    seq_divider8_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q, state_d;
    logic        err_pend_q, err_pend_d;
    logic [7:0]  rem_acc_q, rem_acc_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  quo_acc_q, quo_acc_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  divisor_q, divisor_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  quotient_q, quotient_d;
    logic [7:0]  remainder_q, remainder_d;
    logic        div_by_zero_q, div_by_zero_d;
    logic        overflow_q, overflow_d;

    logic [8:0]  trial;
    logic        trial_ge;

    // The partial remainder is always below the divisor, so its 9th bit is
    // carried only inside the trial value where it can actually be set.
    assign trial    = {rem_acc_q, shift_q[7]};
    assign trial_ge = (trial >= {1'b0, divisor_q});

    // NOTE: every _d gets its hold value first, so no path leaves a variable
    // unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        err_pend_d    = err_pend_q;
        rem_acc_d     = rem_acc_q;
        shift_d       = shift_q;
        quo_acc_d     = quo_acc_q;
        count_d       = count_q;
        divisor_d     = divisor_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        case (state_q)
            IDLE, DONE: begin
                if (err_pend_q) begin
                    // Error result publishes one cycle after acceptance; the
                    // captured divisor tells which flag applies.
                    err_pend_d    = 1'b0;
                    done_d        = 1'b1;
                    quotient_d    = 8'hFF;
                    remainder_d   = shift_q;
                    div_by_zero_d = (divisor_q == 8'd0);
                    overflow_d    = (divisor_q != 8'd0);
                end else if (bus.start) begin
                    divisor_d     = bus.divisor;
                    shift_d       = bus.dividend[7:0];
                    rem_acc_d     = bus.dividend[15:8];
                    quo_acc_d     = 8'd0;
                    count_d       = 3'd7;
                    quotient_d    = 8'd0;
                    remainder_d   = 8'd0;
                    div_by_zero_d = 1'b0;
                    overflow_d    = 1'b0;
                    if (bus.divisor == 8'd0 || bus.dividend[15:8] >= bus.divisor) begin
                        state_d    = DONE;
                        err_pend_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                shift_d   = shift_q << 1;
                rem_acc_d = trial_ge ? 8'(trial - {1'b0, divisor_q}) : trial[7:0];
                quo_acc_d = {quo_acc_q[6:0], trial_ge};
                if (count_q == 3'd0) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = quo_acc_d;
                    remainder_d = rem_acc_d;
                end else begin
                    count_d = count_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            err_pend_q    <= 1'b0;
            rem_acc_q     <= 8'd0;
            shift_q       <= 8'd0;
            quo_acc_q     <= 8'd0;
            count_q       <= 3'd0;
            divisor_q     <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= 8'd0;
            remainder_q   <= 8'd0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_pend_q    <= err_pend_d;
            rem_acc_q     <= rem_acc_d;
            shift_q       <= shift_d;
            quo_acc_q     <= quo_acc_d;
            count_q       <= count_d;
            divisor_q     <= divisor_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_seq_divider8.sv
// Directed-vector and back-to-back random bench for seq_divider8.
// Expected results come from hand-computed tables and the bench's own arithmetic.
module tb_seq_divider8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seq_divider8_if bus ();

    seq_divider8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive a one-cycle start; returns just after the accepting edge.
    task automatic launch(input logic [15:0] dvd, input logic [7:0] dvs);
        @(negedge clk);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // Counts edges after acceptance until done, with a bound.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 30) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic void model(input logic [15:0] dvd, input logic [7:0] dvs,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int unsigned a, b;
        a = dvd;
        b = dvs;
        dz = (b == 0);
        ov = (b != 0) && ((a >> 8) >= b);
        if (dz || ov) begin
            q = 8'hFF;
            r = dvd[7:0];
        end else begin
            q = 8'(a / b);
            r = 8'(a % b);
        end
    endfunction

    initial begin
        int lat, bcnt, tot;
        logic [15:0] dvd;
        logic [7:0]  dvs, eq, er;
        logic        edz, eov;

        vecs[0]  = '{16'd1000,  8'd7,    8'd142,  8'd6,    1'b0, 1'b0};
        vecs[1]  = '{16'hFEFF,  8'hFF,   8'hFF,   8'hFE,   1'b0, 1'b0};
        vecs[2]  = '{16'hFFFF,  8'hFF,   8'hFF,   8'hFF,   1'b0, 1'b1};
        vecs[3]  = '{16'h1234,  8'h00,   8'hFF,   8'h34,   1'b1, 1'b0};
        vecs[4]  = '{16'h0064,  8'h0A,   8'd10,   8'd0,    1'b0, 1'b0};
        vecs[5]  = '{16'h0000,  8'h05,   8'd0,    8'd0,    1'b0, 1'b0};
        vecs[6]  = '{16'h00FF,  8'h01,   8'hFF,   8'h00,   1'b0, 1'b0};
        vecs[7]  = '{16'h0100,  8'h01,   8'hFF,   8'h00,   1'b0, 1'b1};
        vecs[8]  = '{16'h7FFF,  8'h80,   8'hFF,   8'h7F,   1'b0, 1'b0};
        vecs[9]  = '{16'd12345, 8'd100,  8'd123,  8'd45,   1'b0, 1'b0};
        vecs[10] = '{16'h0005,  8'h09,   8'd0,    8'd5,    1'b0, 1'b0};
        vecs[11] = '{16'h0000,  8'h00,   8'hFF,   8'h00,   1'b1, 1'b0};

        bus.start    = 1'b0;
        bus.dividend = 16'd0;
        bus.divisor  = 8'd0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dz", bus.div_by_zero, 0);
        check("rst_ov", bus.overflow, 0);

        foreach (vecs[i]) begin
            launch(vecs[i].dvd, vecs[i].dvs);
            wait_done(lat, bcnt);
            check($sformatf("v%0d_latency", i), lat, (vecs[i].dz || vecs[i].ov) ? 1 : 8);
            check($sformatf("v%0d_busy_cycles", i), bcnt, (vecs[i].dz || vecs[i].ov) ? 0 : 8);
            check($sformatf("v%0d_quotient", i), bus.quotient, vecs[i].q);
            check($sformatf("v%0d_remainder", i), bus.remainder, vecs[i].r);
            check($sformatf("v%0d_dz", i), bus.div_by_zero, vecs[i].dz);
            check($sformatf("v%0d_ov", i), bus.overflow, vecs[i].ov);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), bus.done, 0);
            check($sformatf("v%0d_hold_q", i), bus.quotient, vecs[i].q);
        end

        // Start pulsed during RUN cycle 3 must be ignored.
        launch(16'd1000, 8'd7);
        repeat (3) @(negedge clk);
        check("ign_q_cleared_in_run", bus.quotient, 0);
        bus.dividend = 16'hFFFF;
        bus.divisor  = 8'h00;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        check("ign_still_busy", bus.busy, 1);
        wait_done(lat, bcnt);
        tot = lat + 4;
        check("ign_latency", tot, 8);
        check("ign_quotient", bus.quotient, 142);
        check("ign_remainder", bus.remainder, 6);
        check("ign_dz", bus.div_by_zero, 0);
        check("ign_ov", bus.overflow, 0);
        @(negedge clk);

        // Asynchronous reset during RUN cycle 5 discards the operation.
        launch(16'h0964, 8'h11);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_quotient", bus.quotient, 0);
        check("arst_remainder", bus.remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(lat, bcnt);
        check("arst_no_stale_done", lat, 30);
        launch(16'h0064, 8'h0A);
        wait_done(lat, bcnt);
        check("post_rst_latency", lat, 8);
        check("post_rst_quotient", bus.quotient, 10);
        check("post_rst_remainder", bus.remainder, 0);
        @(negedge clk);

        // Back-to-back operations with start held high.
        for (int i = 0; i < 300; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                dvs = 8'd0;
                dvd = 16'($urandom);
            end else if (sel == 1) begin
                dvs = 8'($urandom_range(1, 255));
                dvd = {8'($urandom_range(int'(dvs), 255)), 8'($urandom)};
            end else begin
                dvs = 8'($urandom_range(1, 255));
                dvd = 16'($urandom_range(0, int'(dvs) * 256 - 1));
            end
            model(dvd, dvs, eq, er, edz, eov);
            bus.dividend = dvd;
            bus.divisor  = dvs;
            bus.start    = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (bus.done !== 1'b1 && lat < 30);
            check($sformatf("b2b%0d_latency %h/%h", i, dvd, dvs), lat, (edz || eov) ? 2 : 9);
            check($sformatf("b2b%0d_quotient %h/%h", i, dvd, dvs), bus.quotient, eq);
            check($sformatf("b2b%0d_remainder %h/%h", i, dvd, dvs), bus.remainder, er);
            check($sformatf("b2b%0d_dz", i), bus.div_by_zero, edz);
            check($sformatf("b2b%0d_ov", i), bus.overflow, eov);
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
